// File: rtl/rcvr_pkg.sv
// rcvr_pkg: types and constants shared by the rcvr sequencing controller and its frame FIFO.
package rcvr_pkg;

  localparam int         RCVR_FRM_W      = 20;
  localparam logic [4:0] RCVR_FULL_BITS  = 5'd22;
  localparam logic [1:0] RCVR_FULL_PHASE = 2'd3;
  localparam logic [3:0] RCVR_SYNC_A     = 4'b1100;
  localparam logic [3:0] RCVR_SYNC_B     = 4'b1000;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RX   = 2'd2,
    HOLD = 2'd3
  } rcvr_state_t;

  typedef logic [RCVR_FRM_W-1:0] rcvr_frm_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rcvr_frm_fifo.sv
// rcvr_frm_fifo: synchronous FIFO for received frames; head word is read straight from storage.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module rcvr_frm_fifo
  import rcvr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = RCVR_FRM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rcvr_ctrl.sv
// rcvr_ctrl: gates rcvr's sysrdy around each frame, classifies frames, queues good ones.
// Link watchdog is built only when RCVR_CTRL_WDOG_EN is defined.
//
//   state | meaning
//   INIT  | startup wait, sysrdy low
//   IDLE  | sysrdy high, waiting for clk1x_en
//   RX    | frame in progress, shadows follow receiver status
//   HOLD  | inter-frame gap, sysrdy low
module rcvr_ctrl
  import rcvr_pkg::*;
#(
  parameter int STARTUP_CYC = 64,
  parameter int HOLDOFF_CYC = 8,
  parameter int RX_MAX_CYC  = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int WDOG_CYC    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk1x_en,
  input  logic [1:0]  clk_div,
  input  logic [4:0]  no_bits_rcvd,
  input  logic        over,
  input  logic [19:0] tsr,
  output logic        sysrdy,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic [3:0]  frm_cmd,
  output logic [15:0] frm_data,
  output logic        sync_a,
  output logic        sync_b,
  output logic [7:0]  err_cnt,
  output logic        ovf,
  output logic        link_ok
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("rcvr_ctrl: FIFO_DEPTH must be a power of two, at least 2");
  end
  if ((WDOG_CYC < 1) || (WDOG_CYC > 8191)) begin : g_bad_wdog
    $error("rcvr_ctrl: WDOG_CYC must fit the 13-bit watchdog counter");
  end

  // One down-counter serves startup, abort and hold-off; RX load makes the IDLE sample count toward the limit.
  localparam logic [15:0] INIT_LOAD = 16'(STARTUP_CYC - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYC - 1);
  localparam logic [15:0] RX_LOAD   = 16'(RX_MAX_CYC - 2);

  rcvr_state_t state;
  rcvr_state_t nxt;
  logic [15:0] tmr;
  logic [15:0] tmr_nxt;
  logic        cls;
  logic        abort;

  rcvr_frm_t   sh_tsr;
  logic [4:0]  sh_bits;
  logic [1:0]  sh_div;
  logic        over_seen;
  logic        over_any;
  logic        is_sync;
  logic        is_good;
  logic        is_bad;

  logic        sysrdy_q;
  logic        sync_a_q;
  logic        sync_b_q;
  logic [7:0]  err_q;
  logic        ovf_q;
  logic        link_q;

  logic        fifo_full;
  logic        fifo_empty;
  logic        frm_pop;
  rcvr_frm_t   fifo_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      tmr   <= INIT_LOAD;
    end else begin
      state <= nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    tmr_nxt = tmr;
    cls     = 1'b0;
    abort   = 1'b0;
    case (state)
      INIT: begin
        if (tmr == '0) nxt = IDLE;
        else           tmr_nxt = tmr - 16'd1;
      end
      IDLE: begin
        if (clk1x_en) begin
          nxt     = RX;
          tmr_nxt = RX_LOAD;
        end
      end
      RX: begin
        if (!clk1x_en) begin
          cls     = 1'b1;
          nxt     = HOLD;
          tmr_nxt = HOLD_LOAD;
        end else if (tmr == '0) begin
          abort   = 1'b1;
          nxt     = HOLD;
          tmr_nxt = HOLD_LOAD;
        end else begin
          tmr_nxt = tmr - 16'd1;
        end
      end
      HOLD: begin
        if (tmr == '0) nxt = IDLE;
        else           tmr_nxt = tmr - 16'd1;
      end
      default: nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_tsr    <= '0;
      sh_bits   <= '0;
      sh_div    <= '0;
      over_seen <= 1'b0;
    end else begin
      if (clk1x_en && ((state == IDLE) || (state == RX))) begin
        sh_tsr  <= tsr;
        sh_bits <= no_bits_rcvd;
        sh_div  <= clk_div;
      end
      if (state == IDLE) begin
        over_seen <= clk1x_en & over;
      end else if ((state == RX) && clk1x_en && over) begin
        over_seen <= 1'b1;
      end
    end
  end

  // The sync pulse may coincide with the receiver dropping clk1x_en.
  assign over_any = over_seen | over;
  assign is_sync  = cls && over_any;
  assign is_good  = cls && !over_any && (sh_bits == RCVR_FULL_BITS) && (sh_div == RCVR_FULL_PHASE);
  assign is_bad   = (cls && !over_any && !is_good) || abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sysrdy_q <= 1'b0;
      sync_a_q <= 1'b0;
      sync_b_q <= 1'b0;
      err_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sysrdy_q <= (nxt == IDLE);
      sync_a_q <= is_sync && (sh_tsr[3:0] == RCVR_SYNC_A);
      sync_b_q <= is_sync && (sh_tsr[3:0] == RCVR_SYNC_B);
      if (is_bad) err_q <= sat_inc8(err_q);
      if (is_good && fifo_full && !frm_pop) ovf_q <= 1'b1;
    end
  end

`ifdef RCVR_CTRL_WDOG_EN
  localparam logic [12:0] WDOG_LIM = 13'(WDOG_CYC);

  logic [12:0] wdog_cnt;
  logic [12:0] wdog_inc;

  assign wdog_inc = (wdog_cnt == WDOG_LIM) ? wdog_cnt : wdog_cnt + 13'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      link_q   <= 1'b0;
    end else if (is_good || is_sync) begin
      wdog_cnt <= '0;
      link_q   <= 1'b1;
    end else begin
      wdog_cnt <= wdog_inc;
      if (wdog_inc == WDOG_LIM) link_q <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) link_q <= 1'b0;
    else        link_q <= (nxt != INIT);
  end
`endif

  assign frm_pop = frm_valid && frm_ready;

  rcvr_frm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RCVR_FRM_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (is_good),
    .pop   (frm_pop),
    .din   (sh_tsr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign frm_valid = !fifo_empty;
  assign frm_cmd   = fifo_dout[19:16];
  assign frm_data  = fifo_dout[15:0];
  assign sysrdy    = sysrdy_q;
  assign sync_a    = sync_a_q;
  assign sync_b    = sync_b_q;
  assign err_cnt   = err_q;
  assign ovf       = ovf_q;
  assign link_ok   = link_q;

endmodule

// File: tb/tb_rcvr_ctrl.sv
// tb_rcvr_ctrl: directed bench for rcvr_ctrl; emulates the receiver's status outputs frame by frame.
// Watchdog steps are compiled in when RCVR_CTRL_WDOG_EN is defined.
module tb_rcvr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk1x_en = 1'b0;
  logic [1:0]  clk_div = '0;
  logic [4:0]  no_bits_rcvd = '0;
  logic        over = 1'b0;
  logic [19:0] tsr = '0;
  logic        sysrdy;
  logic        frm_valid;
  logic        frm_ready = 1'b0;
  logic [3:0]  frm_cmd;
  logic [15:0] frm_data;
  logic        sync_a;
  logic        sync_b;
  logic [7:0]  err_cnt;
  logic        ovf;
  logic        link_ok;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rcvr_ctrl #(
    .STARTUP_CYC (64),
    .HOLDOFF_CYC (8),
    .RX_MAX_CYC  (128),
    .FIFO_DEPTH  (4),
    .WDOG_CYC    (256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk1x_en     (clk1x_en),
    .clk_div      (clk_div),
    .no_bits_rcvd (no_bits_rcvd),
    .over         (over),
    .tsr          (tsr),
    .sysrdy       (sysrdy),
    .frm_valid    (frm_valid),
    .frm_ready    (frm_ready),
    .frm_cmd      (frm_cmd),
    .frm_data     (frm_data),
    .sync_a       (sync_a),
    .sync_b       (sync_b),
    .err_cnt      (err_cnt),
    .ovf          (ovf),
    .link_ok      (link_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 300; i++) begin
      if (sysrdy === 1'b1) break;
      tick();
    end
    chk("sysrdy_wait", 32'(sysrdy), 32'd1);
  endtask

  // Holds clk1x_en for len cycles, optional over on the last busy cycle,
  // then returns just after the edge that classifies the frame.
  task automatic send_frame(input logic [19:0] word, input logic [4:0] nb,
                            input logic [1:0] cd, input logic ovr, input int len);
    wait_rdy();
    clk1x_en     = 1'b1;
    tsr          = word;
    no_bits_rcvd = nb;
    clk_div      = cd;
    for (int i = 0; i < len; i++) begin
      if (ovr && (i == len - 1)) over = 1'b1;
      tick();
      if (i == 0) chk("sysrdy_drop", 32'(sysrdy), 32'd0);
    end
    clk1x_en = 1'b0;
    over     = 1'b0;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sysrdy"},  32'(sysrdy),    32'd0);
    chk({tag, "_valid"},   32'(frm_valid), 32'd0);
    chk({tag, "_cmd"},     32'(frm_cmd),   32'd0);
    chk({tag, "_data"},    32'(frm_data),  32'd0);
    chk({tag, "_sync_a"},  32'(sync_a),    32'd0);
    chk({tag, "_sync_b"},  32'(sync_b),    32'd0);
    chk({tag, "_err"},     32'(err_cnt),   32'd0);
    chk({tag, "_ovf"},     32'(ovf),       32'd0);
    chk({tag, "_link_ok"}, 32'(link_ok),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #10;
    chk_reset_vals("rst");

    // Startup: sysrdy rises on the 64th edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (63) tick();
    chk("init_63_sysrdy", 32'(sysrdy), 32'd0);
    tick();
    chk("init_64_sysrdy", 32'(sysrdy), 32'd1);
`ifdef RCVR_CTRL_WDOG_EN
    chk("init_link_ok", 32'(link_ok), 32'd0);
`else
    chk("init_link_ok", 32'(link_ok), 32'd1);
`endif

    // Good frame, consumer ready: one-cycle valid with A/1234.
    frm_ready = 1'b1;
    send_frame(20'hA1234, 5'd22, 2'd3, 1'b0, 4);
    chk("good_valid", 32'(frm_valid), 32'd1);
    chk("good_cmd",   32'(frm_cmd),   32'hA);
    chk("good_data",  32'(frm_data),  32'h1234);
    chk("good_err",   32'(err_cnt),   32'd0);
    tick();
    chk("good_popped", 32'(frm_valid), 32'd0);
`ifdef RCVR_CTRL_WDOG_EN
    chk("wdog_up", 32'(link_ok), 32'd1);
    repeat (254) tick();
    chk("wdog_255", 32'(link_ok), 32'd1);
    tick();
    chk("wdog_256", 32'(link_ok), 32'd0);
`endif

    // Sync frames.
    send_frame(20'h0000C, 5'd10, 2'd1, 1'b1, 3);
    chk("sync_a_pulse", 32'(sync_a), 32'd1);
    chk("sync_a_not_b", 32'(sync_b), 32'd0);
    chk("sync_a_nopush", 32'(frm_valid), 32'd0);
    tick();
    chk("sync_a_end", 32'(sync_a), 32'd0);
    send_frame(20'h00008, 5'd10, 2'd1, 1'b1, 3);
    chk("sync_b_pulse", 32'(sync_b), 32'd1);
    chk("sync_b_not_a", 32'(sync_a), 32'd0);
    tick();
    chk("sync_b_end", 32'(sync_b), 32'd0);
    chk("sync_b_nopush", 32'(frm_valid), 32'd0);

    // Parity error: receiver ends early; then hold-off gap of 9 cycles from clk1x_en drop.
    send_frame(20'hA1234, 5'd21, 2'd3, 1'b0, 4);
    chk("bad_err", 32'(err_cnt), 32'd1);
    chk("bad_nopush", 32'(frm_valid), 32'd0);
    repeat (7) tick();
    chk("gap_8_sysrdy", 32'(sysrdy), 32'd0);
    tick();
    chk("gap_9_sysrdy", 32'(sysrdy), 32'd1);

    // Overflow: five frames into a four-deep FIFO with no consumer.
    frm_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_frame({4'(k), 16'(16'h1000 + k)}, 5'd22, 2'd3, 1'b0, 2);
      if (k == 4) chk("ovf_after_4", 32'(ovf), 32'd0);
    end
    chk("ovf_after_5", 32'(ovf), 32'd1);
    chk("ovf_valid", 32'(frm_valid), 32'd1);
    frm_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", 32'(frm_valid), 32'd1);
      chk("drain_cmd",   32'(frm_cmd),   32'(k));
      chk("drain_data",  32'(frm_data),  32'(16'h1000 + k));
      tick();
    end
    chk("drain_empty", 32'(frm_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    frm_ready = 1'b0;

    // Stuck clk1x_en: abort after 128 busy samples, nothing pushed.
    send_frame(20'h5BEEF, 5'd22, 2'd3, 1'b0, 2);
    chk("pre_abort_data", 32'(frm_data), 32'hBEEF);
    wait_rdy();
    clk1x_en     = 1'b1;
    tsr          = 20'h7CAFE;
    no_bits_rcvd = 5'd22;
    clk_div      = 2'd3;
    repeat (127) tick();
    chk("abort_127_err", 32'(err_cnt), 32'd1);
    tick();
    chk("abort_128_err", 32'(err_cnt), 32'd2);
    clk1x_en  = 1'b0;
    frm_ready = 1'b1;
    tick();
    chk("abort_nopush", 32'(frm_valid), 32'd0);
    frm_ready = 1'b0;

    // Reset in the middle of a frame with a word queued.
    send_frame(20'h3ABCD, 5'd22, 2'd3, 1'b0, 2);
    chk("pre_rst_valid", 32'(frm_valid), 32'd1);
    wait_rdy();
    clk1x_en = 1'b1;
    tick();
    tick();
    chk("mid_rx_sysrdy", 32'(sysrdy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    clk1x_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // err_cnt saturates at 255.
    for (int n = 1; n <= 256; n++) begin
      send_frame(20'h00000, 5'd3, 2'd0, 1'b0, 1);
      if (n == 255) chk("err_255", 32'(err_cnt), 32'd255);
    end
    chk("err_sat", 32'(err_cnt), 32'd255);
    chk("sat_nopush", 32'(frm_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
